maquina_param: RTL and testbench
================================

MAQUINA_PARAM -- requirements
Module: maquina_param

Interface
REQ-001 SHALL have parameter NUM_FIFOS, default 5: number of monitored FIFOs (legal 2..16).
REQ-002 SHALL have parameter UMBRAL_W, default 2: width of each threshold group.
REQ-003 SHALL have parameter IDLE_DLY, default 2: consecutive all-empty cycles required in ACTIVE before returning to IDLE (legal 1..15).
REQ-004 SHALL derive ID_W = max(1, clog2(NUM_FIFOS)).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 init  input  1  request to (re)load thresholds.
REQ-008 error_clr  input  1  acknowledge/clear of the sticky error condition.
REQ-009 Umbrales_MFs, Umbrales_VCs, Umbrales_Ds  input  UMBRAL_W each  threshold values to load.
REQ-010 FIFO_empties  input  NUM_FIFOS  per-FIFO empty flags.
REQ-011 FIFO_errors  input  NUM_FIFOS  per-FIFO overflow/underflow flags.
REQ-012 Umbrales_MFs_internos, Umbrales_VCs_internos, Umbrales_Ds_internos  output  UMBRAL_W each  latched thresholds.
REQ-013 active_out, idle_out, error_out  output  1 each  registered state flags.
REQ-014 error_fifo_id  output  ID_W  index of the lowest-numbered FIFO in error at ERROR entry.
REQ-015 error_count  output  4  saturating count of ERROR entries since reset.

Function
REQ-016 SHALL implement states RESET, INIT, IDLE, ACTIVE, ERROR; all outputs registered.
REQ-017 RESET -> INIT on the first clock edge with reset=1.
REQ-018 INIT: internal thresholds load input thresholds every cycle; stay while init=1; init=0 -> IDLE with last loaded values held.
REQ-019 Transition priority in IDLE and ACTIVE: any FIFO_errors bit -> ERROR; else init=1 -> INIT; else empty logic.
REQ-020 IDLE -> ACTIVE when any FIFO_empties bit is 0.
REQ-021 ACTIVE -> IDLE after FIFO_empties all-ones for IDLE_DLY consecutive cycles; a non-empty cycle restarts the 4-bit counter at 0.
REQ-022 ERROR is sticky: FIFO_errors and init ignored; error_clr=1 -> RESET next cycle.
REQ-023 error_fifo_id SHALL capture the lowest set index of FIFO_errors on the edge entering ERROR and hold it until next ERROR entry or reset.
REQ-024 error_count SHALL increment on each ERROR entry, saturating at 15.
REQ-025 active_out=1 only in ACTIVE, idle_out=1 only in IDLE, error_out=1 only in ERROR; all 0 in RESET and INIT.
REQ-026 Thresholds SHALL change only in INIT; IDLE/ACTIVE/ERROR hold them.
REQ-027 Simultaneous error and init in IDLE/ACTIVE: ERROR wins; init not honoured.

Reset
REQ-028 reset=0 at any edge, any state: state=RESET, all flags 0, internal thresholds 0, error_fifo_id 0, error_count 0, idle counter 0.
REQ-029 reset=0 overrides error_clr and all other inputs.

Structure
REQ-030 State encoding and ID_W computation SHALL live in shared package maquina_pkg.
REQ-031 Lowest-set-bit priority encoder SHALL be sub-module prio_enc (parameter NUM_FIFOS, output ID_W).
REQ-032 Existing maquina SHALL remain unchanged; maquina_param with defaults SHALL match maquina on all shared outputs.

Verification
REQ-033 reset=0 2 cycles, then reset=1, init=1, Umbrales_MFs=2'b11 -> INIT next cycle; internos=2'b11 one cycle later; all flags 0.
REQ-034 init=0, FIFO_empties=5'b11111 -> idle_out=1; then empties=5'b11011 -> active_out=1 next cycle.
REQ-035 IDLE_DLY=2, ACTIVE, empties all-ones 1 cycle, 0 once, all-ones 2 cycles -> idle_out=1 only after the second full run.
REQ-036 ACTIVE, FIFO_errors=5'b10100 and init=1 same cycle -> error_out=1, error_fifo_id=2, error_count=1; later errors/init ignored.
REQ-037 ERROR, error_clr=1 -> RESET then INIT; sixteen error/clear cycles -> error_count stays 15.
REQ-038 NUM_FIFOS=16, UMBRAL_W=4: FIFO_errors bit 15 only -> error_fifo_id=15; reset=0 mid-ACTIVE -> all outputs 0 next edge.

Source files
------------

// File: rtl/maquina_pkg.sv
// Shared definitions for the FIFO supervisor: state encoding, limits and
// the width rule for FIFO index outputs.
package maquina_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [3:0] ERR_CNT_MAX = 4'd15;

  // Width needed to index n FIFOs, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder: reports the smallest index whose request
// bit is set, or zero when no bit is set.
module prio_enc
  import maquina_pkg::*;
#(
  parameter int NUM_FIFOS = 5,
  localparam int ID_W = id_w(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] req,
  output logic [ID_W-1:0]      id
);

  logic found_s;

  // Scan upward and keep the first hit.
  always_comb begin
    id      = {ID_W{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (req[i] && !found_s) begin
        id      = ID_W'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/maquina_param.sv
// Parameterised FIFO supervisor: latches thresholds in INIT, tracks FIFO
// activity between IDLE and ACTIVE, and parks in a sticky ERROR state.
module maquina_param
  import maquina_pkg::*;
#(
  parameter int NUM_FIFOS = 5,
  parameter int UMBRAL_W  = 2,
  parameter int IDLE_DLY  = 2,
  localparam int ID_W = id_w(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 error_clr,
  input  logic [UMBRAL_W-1:0]  Umbrales_MFs,
  input  logic [UMBRAL_W-1:0]  Umbrales_VCs,
  input  logic [UMBRAL_W-1:0]  Umbrales_Ds,
  input  logic [NUM_FIFOS-1:0] FIFO_empties,
  input  logic [NUM_FIFOS-1:0] FIFO_errors,
  output logic [UMBRAL_W-1:0]  Umbrales_MFs_internos,
  output logic [UMBRAL_W-1:0]  Umbrales_VCs_internos,
  output logic [UMBRAL_W-1:0]  Umbrales_Ds_internos,
  output logic                 active_out,
  output logic                 idle_out,
  output logic                 error_out,
  output logic [ID_W-1:0]      error_fifo_id,
  output logic [3:0]           error_count
);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [3:0]      idle_cnt_r;
  logic [3:0]      idle_cnt_nxt_s;
  logic            err_entry_s;
  logic            all_empty_s;
  logic            any_err_s;
  logic [ID_W-1:0] enc_id_s;

  assign all_empty_s = &FIFO_empties;
  assign any_err_s   = |FIFO_errors;

  prio_enc #(.NUM_FIFOS(NUM_FIFOS)) u_prio_enc (
    .req (FIFO_errors),
    .id  (enc_id_s)
  );

  // Next-state logic; errors outrank init, which outranks the empty tracking.
  always_comb begin
    state_nxt_s    = state_r;
    idle_cnt_nxt_s = 4'd0;
    err_entry_s    = 1'b0;
    case (state_r)
      ST_RESET: state_nxt_s = ST_INIT;
      ST_INIT: begin
        if (init) begin
          state_nxt_s = ST_INIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_IDLE, ST_ACTIVE: begin
        if (any_err_s) begin
          state_nxt_s = ST_ERROR;
          err_entry_s = 1'b1;
        end else if (init) begin
          state_nxt_s = ST_INIT;
        end else if (state_r == ST_IDLE) begin
          if (all_empty_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_ACTIVE;
          end
        end else if (all_empty_s) begin
          // Counter holds the number of all-empty cycles already seen.
          if (({1'b0, idle_cnt_r} + 5'd1) >= 5'(IDLE_DLY)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            idle_cnt_nxt_s = idle_cnt_r + 4'd1;
          end
        end else begin
          idle_cnt_nxt_s = 4'd0;
        end
      end
      ST_ERROR: begin
        if (error_clr) begin
          state_nxt_s = ST_RESET;
        end else begin
          state_nxt_s = ST_ERROR;
        end
      end
      default: state_nxt_s = ST_RESET;
    endcase
  end

  // State register and registered outputs; thresholds move only while in INIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r               <= ST_RESET;
      idle_cnt_r            <= 4'd0;
      active_out            <= 1'b0;
      idle_out              <= 1'b0;
      error_out             <= 1'b0;
      Umbrales_MFs_internos <= {UMBRAL_W{1'b0}};
      Umbrales_VCs_internos <= {UMBRAL_W{1'b0}};
      Umbrales_Ds_internos  <= {UMBRAL_W{1'b0}};
      error_fifo_id         <= {ID_W{1'b0}};
      error_count           <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
      active_out <= (state_nxt_s == ST_ACTIVE);
      idle_out   <= (state_nxt_s == ST_IDLE);
      error_out  <= (state_nxt_s == ST_ERROR);
      if (state_r == ST_INIT) begin
        Umbrales_MFs_internos <= Umbrales_MFs;
        Umbrales_VCs_internos <= Umbrales_VCs;
        Umbrales_Ds_internos  <= Umbrales_Ds;
      end
      if (err_entry_s) begin
        error_fifo_id <= enc_id_s;
        if (error_count != ERR_CNT_MAX) begin
          error_count <= error_count + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maquina_param.sv
// Scoreboard bench: two configurations of maquina_param driven with the same
// stimulus and compared every cycle against an integer-level reference model.
module tb_maquina_param;

  localparam int A_N = 5,  A_W = 2, A_D = 2;
  localparam int B_N = 16, B_W = 4, B_D = 3;
  localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;

  typedef struct {
    int st;
    int mf, vc, d;
    int id;
    int ecnt;
    int run;
  } mdl_t;

  logic clk = 1'b1;
  logic reset, init, error_clr;
  logic [A_W-1:0] a_mf, a_vc, a_d, a_mf_q, a_vc_q, a_d_q;
  logic [A_N-1:0] a_emp, a_err;
  logic           a_act, a_idle, a_erro;
  logic [2:0]     a_id;
  logic [3:0]     a_cnt;
  logic [B_W-1:0] b_mf, b_vc, b_d, b_mf_q, b_vc_q, b_d_q;
  logic [B_N-1:0] b_emp, b_err;
  logic           b_act, b_idle, b_erro;
  logic [3:0]     b_id;
  logic [3:0]     b_cnt;

  logic [22:0] qa[$];
  logic [22:0] qb[$];
  mdl_t ma, mb;
  int n_chk = 0, n_pass = 0, cyc_no = 0;

  always #5 clk = ~clk;

  maquina_param #(.NUM_FIFOS(A_N), .UMBRAL_W(A_W), .IDLE_DLY(A_D)) dut_a (
    .clk(clk), .reset(reset), .init(init), .error_clr(error_clr),
    .Umbrales_MFs(a_mf), .Umbrales_VCs(a_vc), .Umbrales_Ds(a_d),
    .FIFO_empties(a_emp), .FIFO_errors(a_err),
    .Umbrales_MFs_internos(a_mf_q), .Umbrales_VCs_internos(a_vc_q),
    .Umbrales_Ds_internos(a_d_q), .active_out(a_act), .idle_out(a_idle),
    .error_out(a_erro), .error_fifo_id(a_id), .error_count(a_cnt));

  maquina_param #(.NUM_FIFOS(B_N), .UMBRAL_W(B_W), .IDLE_DLY(B_D)) dut_b (
    .clk(clk), .reset(reset), .init(init), .error_clr(error_clr),
    .Umbrales_MFs(b_mf), .Umbrales_VCs(b_vc), .Umbrales_Ds(b_d),
    .FIFO_empties(b_emp), .FIFO_errors(b_err),
    .Umbrales_MFs_internos(b_mf_q), .Umbrales_VCs_internos(b_vc_q),
    .Umbrales_Ds_internos(b_d_q), .active_out(b_act), .idle_out(b_idle),
    .error_out(b_erro), .error_fifo_id(b_id), .error_count(b_cnt));

  wire [22:0] act_a = {2'b00, a_mf_q, 2'b00, a_vc_q, 2'b00, a_d_q,
                       a_act, a_idle, a_erro, 1'b0, a_id, a_cnt};
  wire [22:0] act_b = {b_mf_q, b_vc_q, b_d_q, b_act, b_idle, b_erro, b_id, b_cnt};

  // One clock edge of the supervisor, described in terms of its rules.
  function automatic mdl_t step(mdl_t m, bit rst, bit ini, bit ec, int mf, int vc, int d,
                                int emp, int err, int nf, int uw, int dly);
    mdl_t n = m;
    int full = (1 << nf) - 1;
    int tmask = (1 << uw) - 1;
    emp = emp & full;
    err = err & full;
    if (!rst) begin
      n = '{S_RESET, 0, 0, 0, 0, 0, 0};
      return n;
    end
    n.run = 0;
    if (m.st == S_RESET) n.st = S_INIT;
    else if (m.st == S_INIT) begin
      n.mf = mf & tmask; n.vc = vc & tmask; n.d = d & tmask;
      n.st = ini ? S_INIT : S_IDLE;
    end else if (m.st == S_IDLE || m.st == S_ACTIVE) begin
      if (err != 0) begin
        n.st = S_ERROR;
        n.ecnt = (m.ecnt < 15) ? m.ecnt + 1 : 15;
        n.id = -1;
        for (int k = 0; k < nf; k++) if (((err >> k) & 1) == 1 && n.id < 0) n.id = k;
      end else if (ini) n.st = S_INIT;
      else if (m.st == S_IDLE) n.st = (emp == full) ? S_IDLE : S_ACTIVE;
      else if (emp == full) begin
        if (m.run + 1 >= dly) n.st = S_IDLE;
        else n.run = m.run + 1;
      end
    end else if (m.st == S_ERROR) begin
      if (ec) n.st = S_RESET;
    end
    return n;
  endfunction

  function automatic logic [22:0] pk(mdl_t m);
    logic [22:0] v;
    v = {m.mf[3:0], m.vc[3:0], m.d[3:0], m.st == S_ACTIVE, m.st == S_IDLE,
         m.st == S_ERROR, m.id[3:0], m.ecnt[3:0]};
    return v;
  endfunction

  task automatic cyc(bit r, bit ini, bit ec, int mf, int vc, int d, int emp, int err);
    @(negedge clk);
    reset = r; init = ini; error_clr = ec;
    a_mf = mf[1:0]; a_vc = vc[1:0]; a_d = d[1:0];
    b_mf = mf[3:0]; b_vc = vc[3:0]; b_d = d[3:0];
    a_emp = emp[4:0]; a_err = err[4:0];
    b_emp = emp[15:0]; b_err = err[15:0];
    ma = step(ma, r, ini, ec, mf, vc, d, emp, err, A_N, A_W, A_D);
    mb = step(mb, r, ini, ec, mf, vc, d, emp, err, B_N, B_W, B_D);
    qa.push_back(pk(ma));
    qb.push_back(pk(mb));
  endtask

  task automatic check(string nm, logic [22:0] exp, logic [22:0] got);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h expected=%h (mf,vc,d,act,idle,err,id,cnt)",
                  nm, cyc_no, got, exp);
  endtask

  // Monitor: after every edge, compare the outputs with the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (qa.size() > 0) check("cfg5", qa.pop_front(), act_a);
      if (qb.size() > 0) check("cfg16", qb.pop_front(), act_b);
    end
  end

  initial begin
    ma = '{0, 0, 0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0, 0, 0};
    reset = 1'b0; init = 1'b0; error_clr = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 'hFFFF, 0);
    cyc(0, 0, 0, 0, 0, 0, 'hFFFF, 0);
    cyc(1, 1, 0, 3, 1, 2, 'hFFFF, 0);
    cyc(1, 1, 0, 3, 1, 2, 'hFFFF, 0);
    cyc(1, 0, 0, 3, 1, 2, 'hFFFF, 0);
    cyc(1, 0, 0, 0, 0, 0, 'hFFFF, 0);
    cyc(1, 0, 0, 0, 0, 0, 'hFFFB, 0);
    cyc(1, 0, 0, 0, 0, 0, 'hFFFF, 0);
    cyc(1, 0, 0, 0, 0, 0, 'hFFFB, 0);
    cyc(1, 0, 0, 0, 0, 0, 'hFFFF, 0);
    cyc(1, 0, 0, 0, 0, 0, 'hFFFF, 0);
    cyc(1, 0, 0, 0, 0, 0, 'hFFFB, 0);
    cyc(1, 1, 0, 1, 1, 1, 'hFFFB, 'h14);
    cyc(1, 1, 0, 1, 1, 1, 'hFFFB, 'h01);
    cyc(1, 0, 0, 1, 1, 1, 'hFFFF, 'h03);
    cyc(1, 0, 1, 1, 1, 1, 'hFFFF, 0);
    cyc(1, 1, 0, 2, 3, 1, 'hFFFF, 0);
    cyc(1, 0, 0, 2, 3, 1, 'hFFFF, 0);
    for (int k = 0; k < 17; k++) begin
      cyc(1, 0, 0, 0, 0, 0, 'hFFFF, 'h01);
      cyc(1, 0, 1, 0, 0, 0, 'hFFFF, 0);
      cyc(1, 0, 0, 0, 0, 0, 'hFFFF, 0);
      cyc(1, 0, 0, 0, 0, 0, 'hFFFF, 0);
    end
    cyc(1, 0, 0, 0, 0, 0, 'h0000, 0);
    cyc(1, 0, 0, 0, 0, 0, 'h0000, 'h8000);
    cyc(0, 1, 1, 3, 3, 3, 'h0000, 'h0001);
    for (int k = 0; k < 800; k++) begin
      cyc($urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
          ($urandom_range(0, 1) == 1) ? 'hFFFF : $urandom_range(0, 65535),
          ($urandom_range(0, 15) == 0) ? $urandom_range(1, 65535) : 0);
    end
    @(posedge clk);
    #2;
    for (int k = 0; k < 10 && (qa.size() + qb.size()) > 0; k++) @(posedge clk);
    #2;
    n_chk++;
    if ((qa.size() + qb.size()) == 0) n_pass++;
    else $display("FAIL drain pending=%0d required=0", qa.size() + qb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
